// File: rtl/uart_imem_loader.sv
// Program-load writer for the instruction RAM: an 8N1 UART receiver feeding a
// length-prefixed, big-endian word assembler that drives the RAM write port.
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int ADDR_WIDTH   = 14
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  uart_rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           words_loaded
);

    localparam int                 CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [16:0]        MAX_WORDS = 17'(1) << ADDR_WIDTH;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rxState_t;
    typedef enum logic [2:0] {L_IDLE, L_LEN_HI, L_LEN_LO, L_DATA, L_DONE} lState_t;

    logic                  rxMeta_q, rxSync_q;
    rxState_t              rxState_q, rxState_d;
    logic [CNT_W-1:0]      rxCnt_q, rxCnt_d;
    logic [2:0]            rxBit_q, rxBit_d;
    logic [7:0]            rxShift_q, rxShift_d;
    logic                  byteValid, frameErr;
    logic [7:0]            byteData;

    lState_t               lState_q, lState_d;
    logic [7:0]            lenHi_q, lenHi_d;
    logic [15:0]           wordCount_q, wordCount_d;
    logic [31:0]           word_q, word_d;
    logic [1:0]            byteIdx_q, byteIdx_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wordsLoaded_q, wordsLoaded_d;
    logic                  we_q, we_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    assign byteData     = rxShift_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = wordsLoaded_q;

    // Two-flop synchronizer for the asynchronous serial line, idling high.
    always_ff @(posedge clock) begin
        if (reset) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
        end else begin
            rxMeta_q <= uart_rx;
            rxSync_q <= rxMeta_q;
        end
    end

    // Receiver state, bit-timing counter and shift register.
    always_ff @(posedge clock) begin
        if (reset) begin
            rxState_q <= RX_IDLE;
            rxCnt_q   <= '0;
            rxBit_q   <= '0;
            rxShift_q <= '0;
        end else begin
            rxState_q <= rxState_d;
            rxCnt_q   <= rxCnt_d;
            rxBit_q   <= rxBit_d;
            rxShift_q <= rxShift_d;
        end
    end

    // Receiver next state: mid-bit sampling, LSB first, one-cycle byte/frame-error strobes.
    always_comb begin
        rxState_d = rxState_q;
        rxCnt_d   = rxCnt_q;
        rxBit_d   = rxBit_q;
        rxShift_d = rxShift_q;
        byteValid = 1'b0;
        frameErr  = 1'b0;
        case (rxState_q)
            RX_IDLE: begin
                if (!rxSync_q) begin
                    rxState_d = RX_START;
                    rxCnt_d   = '0;
                    rxBit_d   = '0;
                end
            end
            RX_START: begin
                if (rxCnt_q == HALF_CNT) begin
                    rxCnt_d   = '0;
                    rxState_d = rxSync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rxCnt_d = rxCnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (rxCnt_q == FULL_CNT) begin
                    rxCnt_d   = '0;
                    rxShift_d = {rxSync_q, rxShift_q[7:1]};
                    if (rxBit_q == 3'd7) begin
                        rxState_d = RX_STOP;
                    end else begin
                        rxBit_d = rxBit_q + 3'd1;
                    end
                end else begin
                    rxCnt_d = rxCnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (rxCnt_q == FULL_CNT) begin
                    rxCnt_d   = '0;
                    rxState_d = RX_IDLE;
                    if (rxSync_q) begin
                        byteValid = 1'b1;
                    end else begin
                        frameErr = 1'b1;
                    end
                end else begin
                    rxCnt_d = rxCnt_q + CNT_W'(1);
                end
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    // Loader state and every registered output.
    always_ff @(posedge clock) begin
        if (reset) begin
            lState_q      <= L_IDLE;
            lenHi_q       <= '0;
            wordCount_q   <= '0;
            word_q        <= '0;
            byteIdx_q     <= '0;
            addr_q        <= '0;
            wordsLoaded_q <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            lState_q      <= lState_d;
            lenHi_q       <= lenHi_d;
            wordCount_q   <= wordCount_d;
            word_q        <= word_d;
            byteIdx_q     <= byteIdx_d;
            addr_q        <= addr_d;
            wordsLoaded_q <= wordsLoaded_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    // Loader protocol: header length check, word assembly, write then advance the index.
    always_comb begin
        lState_d      = lState_q;
        lenHi_d       = lenHi_q;
        wordCount_d   = wordCount_q;
        word_d        = word_q;
        byteIdx_d     = byteIdx_q;
        addr_d        = addr_q;
        wordsLoaded_d = wordsLoaded_q;
        we_d          = 1'b0;
        wdata_d       = wdata_q;
        busy_d        = busy_q;
        done_d        = done_q;
        err_d         = err_q;
        if (frameErr && (lState_q != L_IDLE)) begin
            err_d    = 1'b1;
            busy_d   = 1'b0;
            lState_d = L_IDLE;
        end else begin
            case (lState_q)
                L_IDLE: begin
                    if (start) begin
                        lState_d      = L_LEN_HI;
                        busy_d        = 1'b1;
                        done_d        = 1'b0;
                        err_d         = 1'b0;
                        wordsLoaded_d = '0;
                        addr_d        = '0;
                    end
                end
                L_LEN_HI: begin
                    if (byteValid) begin
                        lenHi_d  = byteData;
                        lState_d = L_LEN_LO;
                    end
                end
                L_LEN_LO: begin
                    if (byteValid) begin
                        wordCount_d = {lenHi_q, byteData};
                        byteIdx_d   = '0;
                        if ({lenHi_q, byteData} == 16'd0) begin
                            lState_d = L_DONE;
                        end else if ({1'b0, lenHi_q, byteData} > MAX_WORDS) begin
                            err_d    = 1'b1;
                            busy_d   = 1'b0;
                            lState_d = L_IDLE;
                        end else begin
                            lState_d = L_DATA;
                        end
                    end
                end
                L_DATA: begin
                    if (we_q) begin
                        wordsLoaded_d = wordsLoaded_q + 16'd1;
                        if (addr_q != '1) begin
                            addr_d = addr_q + ADDR_WIDTH'(1);
                        end
                        if ((wordsLoaded_q + 16'd1) == wordCount_q) begin
                            lState_d = L_DONE;
                        end
                    end else if (byteValid) begin
                        word_d    = {word_q[23:0], byteData};
                        byteIdx_d = byteIdx_q + 2'd1;
                        if (byteIdx_q == 2'd3) begin
                            we_d    = 1'b1;
                            wdata_d = {word_q[23:0], byteData};
                        end
                    end
                end
                L_DONE: begin
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    lState_d = L_IDLE;
                end
                default: lState_d = L_IDLE;
            endcase
        end
    end

endmodule
